bram_sdp_ctrl: RTL and testbench

BRAM_SDP_CTRL -- requirements
Module: bram_sdp_ctrl

---
 rtl/bram_sdp_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_bram_sdp_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/bram_sdp_ctrl.sv
// rtl/bram_sdp_ctrl.sv - simple dual-port block RAM with byte-enable writes, pipelined reads and optional clear engine
//
// Ports:
//   clka, rstn          clock (rising edge) and asynchronous active-low reset
//   addra, dina, wea    write port: word address, data, per-byte enables
//   addrb, reb          read port: word address, read strobe
//   doutb, doutb_valid  read data and its one-cycle qualifier
//   init_req, init_busy memory clear request and clear-in-progress flag
//
// Build option: define BRAM_CLEAR_EN to compile in the clear engine.
// Without it the array powers up undefined, init_busy is 0 and init_req is ignored.

module bram_sdp_ctrl #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int OUT_REG    = 1
) (
    input  logic                    clka,
    input  logic                    rstn,
    input  logic [ADDR_WIDTH-1:0]   addra,
    input  logic [DATA_WIDTH-1:0]   dina,
    input  logic [DATA_WIDTH/8-1:0] wea,
    input  logic [ADDR_WIDTH-1:0]   addrb,
    input  logic                    reb,
    output logic [DATA_WIDTH-1:0]   doutb,
    output logic                    doutb_valid,
    input  logic                    init_req,
    output logic                    init_busy
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic                  in_clear;
    logic [ADDR_WIDTH-1:0] clr_addr;

`ifdef BRAM_CLEAR_EN
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;

    always_ff @(posedge clka or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // init_req is only looked at in IDLE, so pulses during a sweep
    // neither restart it nor reload the counter.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (init_req) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end
            end
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == {ADDR_WIDTH{1'b1}}) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign in_clear = (state_q == ST_CLEAR);
    assign clr_addr = clr_cnt_q;
`else
    logic unused_init_req;

    assign unused_init_req = init_req;
    assign in_clear        = 1'b0;
    assign clr_addr        = '0;
`endif

    assign init_busy = in_clear;

    // Single write port shared between user writes and the zero sweep.
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [NB-1:0]         wr_be;
    logic [DATA_WIDTH-1:0] wr_data;

    always_comb begin
        wr_addr = addra;
        wr_be   = wea;
        wr_data = dina;
        if (in_clear) begin
            wr_addr = clr_addr;
            wr_be   = '1;
            wr_data = '0;
        end
    end

    logic rd_en;
    logic col_hit;

    assign rd_en   = reb & ~in_clear;
    assign col_hit = rd_en & (|wea) & (addra == addrb);

    // Array and its read register carry no reset so they map onto block RAM.
    // The read register captures pre-write contents; write-first collision
    // data is merged in one stage later.
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] ram_q;

    always_ff @(posedge clka) begin
        for (int i = 0; i < NB; i++) begin
            if (wr_be[i]) begin
                mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
        if (rd_en) begin
            ram_q <= mem[addrb];
        end
    end

    logic                  v1_q;
    logic                  col_hit_q;
    logic [NB-1:0]         col_be_q;
    logic [DATA_WIDTH-1:0] col_data_q;

    always_ff @(posedge clka or negedge rstn) begin
        if (!rstn) begin
            v1_q       <= 1'b0;
            col_hit_q  <= 1'b0;
            col_be_q   <= '0;
            col_data_q <= '0;
        end else begin
            v1_q <= rd_en;
            if (rd_en) begin
                col_hit_q  <= col_hit;
                col_be_q   <= wea;
                col_data_q <= dina;
            end
        end
    end

    logic [DATA_WIDTH-1:0] merged;

    always_comb begin
        merged = ram_q;
        for (int i = 0; i < NB; i++) begin
            if (col_hit_q && col_be_q[i]) begin
                merged[8*i +: 8] = col_data_q[8*i +: 8];
            end
        end
    end

    logic                  fin_valid;
    logic [DATA_WIDTH-1:0] fin_data;

    if (OUT_REG != 0) begin : g_oreg
        logic                  v2_q;
        logic [DATA_WIDTH-1:0] d2_q;

        always_ff @(posedge clka or negedge rstn) begin
            if (!rstn) begin
                v2_q <= 1'b0;
                d2_q <= '0;
            end else begin
                v2_q <= v1_q;
                if (v1_q) begin
                    d2_q <= merged;
                end
            end
        end

        assign fin_valid = v2_q;
        assign fin_data  = d2_q;
    end else begin : g_noreg
        assign fin_valid = v1_q;
        assign fin_data  = merged;
    end

    // doutb only moves when a read completes, so it holds between reads.
    always_ff @(posedge clka or negedge rstn) begin
        if (!rstn) begin
            doutb       <= '0;
            doutb_valid <= 1'b0;
        end else begin
            doutb_valid <= fin_valid;
            if (fin_valid) begin
                doutb <= fin_data;
            end
        end
    end

endmodule

// File: tb/tb_bram_sdp_ctrl.sv
// tb/tb_bram_sdp_ctrl.sv - scoreboard bench for bram_sdp_ctrl, OUT_REG=0 and OUT_REG=1 instances side by side

module tb_bram_sdp_ctrl;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int NB    = DW / 8;
    localparam int DEPTH = 2 ** AW;

`ifdef BRAM_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstn;
    logic [AW-1:0] addra, addrb;
    logic [DW-1:0] dina;
    logic [NB-1:0] wea;
    logic          reb, init_req;

    logic [DW-1:0] doutb_w [2];
    logic          valid_w [2];
    logic          busy_w  [2];

    bram_sdp_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(0)) u_dut0 (
        .clka(clk), .rstn(rstn), .addra(addra), .dina(dina), .wea(wea),
        .addrb(addrb), .reb(reb), .doutb(doutb_w[0]), .doutb_valid(valid_w[0]),
        .init_req(init_req), .init_busy(busy_w[0])
    );

    bram_sdp_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(1)) u_dut1 (
        .clka(clk), .rstn(rstn), .addra(addra), .dina(dina), .wea(wea),
        .addrb(addrb), .reb(reb), .doutb(doutb_w[1]), .doutb_valid(valid_w[1]),
        .init_req(init_req), .init_busy(busy_w[1])
    );

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t          exp_q [2][$];
    logic [DW-1:0] mem_m [DEPTH];
    logic [DW-1:0] last_d [2];
    int            busy_left = 0;
    int            cyc = 0;
    int            n_checks = 0;
    int            n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endfunction

    // Monitor: pops the scoreboard whenever a DUT presents read data.
    always begin : mon
        exp_t e;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            if (!rstn) begin
                last_d[i] = '0;
            end else if (valid_w[i]) begin
                if (exp_q[i].size() == 0) begin
                    chk($sformatf("spurious_valid_%0d", i), DW'(valid_w[i]), '0);
                end else begin
                    e = exp_q[i].pop_front();
                    chk($sformatf("read_data_%0d", i), doutb_w[i], e.data);
                    chk($sformatf("read_latency_%0d", i), DW'(cyc), DW'(e.due));
                end
                last_d[i] = doutb_w[i];
            end else begin
                chk($sformatf("doutb_hold_%0d", i), doutb_w[i], last_d[i]);
                if (exp_q[i].size() > 0 && exp_q[i][0].due <= cyc) begin
                    chk($sformatf("missing_valid_%0d", i), DW'(valid_w[i]), DW'(1));
                    void'(exp_q[i].pop_front());
                end
            end
        end
    end

    // One clock of stimulus, called at a falling edge; the reference model
    // describes what the following rising edge does.
    task automatic step(input logic [NB-1:0] w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic r, input logic [AW-1:0] ra, input logic ir);
        chk("init_busy_0", DW'(busy_w[0]), DW'(busy_left > 0));
        chk("init_busy_1", DW'(busy_w[1]), DW'(busy_left > 0));
        wea = w; addra = wa; dina = wd; reb = r; addrb = ra; init_req = ir;
        if (busy_left > 0) begin
            busy_left--;
        end else begin
            for (int b = 0; b < NB; b++)
                if (w[b]) mem_m[wa][8*b +: 8] = wd[8*b +: 8];
            if (r) begin
                exp_q[0].push_back('{mem_m[ra], cyc + 2});
                exp_q[1].push_back('{mem_m[ra], cyc + 3});
            end
            if (ir && CLR) begin
                for (int a = 0; a < DEPTH; a++) mem_m[a] = '0;
                busy_left = DEPTH;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        step('0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        step('0, '0, '0, 1'b1, a, 1'b0);
    endtask

    task automatic wait_idle();
        for (int g = 0; g < 2 * DEPTH && busy_left > 0; g++) idle();
    endtask

    task automatic do_reset(input int n);
        wea = '0; reb = 1'b0; init_req = 1'b0;
        rstn = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("reset_doutb_%0d", i), doutb_w[i], '0);
            chk($sformatf("reset_valid_%0d", i), DW'(valid_w[i]), '0);
            chk($sformatf("reset_busy_%0d", i), DW'(busy_w[i]), DW'(CLR));
            exp_q[i].delete();
        end
        busy_left = CLR ? DEPTH : 0;
        if (CLR) for (int a = 0; a < DEPTH; a++) mem_m[a] = '0;
        repeat (n) @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rstn = 1'b0; wea = '0; addra = '0; dina = '0; reb = 1'b0; addrb = '0; init_req = 1'b0;
        @(negedge clk);
        do_reset(2);
        wait_idle();
`ifndef BRAM_CLEAR_EN
        for (int a = 0; a < DEPTH; a++) step('1, AW'(a), DW'($urandom), 1'b0, '0, 1'b0);
`endif
        for (int a = 0; a < DEPTH; a++) rd(AW'(a));

        // byte enables
        step(4'hF, 4'd5, 32'hAABBCCDD, 1'b0, '0, 1'b0);
        step(4'b0101, 4'd5, 32'h11223344, 1'b0, '0, 1'b0);
        rd(4'd5);

        // back-to-back reads
        rd(4'd1); rd(4'd2); rd(4'd3);

        // same-address collision
        step(4'hF, 4'd7, 32'h12345678, 1'b0, '0, 1'b0);
        step(4'b1100, 4'd7, 32'hCAFE0000, 1'b1, 4'd7, 1'b0);
        rd(4'd7);

        // writes and init_req pulses while clearing
        step('0, '0, '0, 1'b1, 4'd5, 1'b1);
        step(4'hF, 4'd2, 32'hFFFFFFFF, 1'b1, 4'd2, 1'b0);
        for (int i = 0; i < 14; i++) step('0, '0, '0, 1'b0, '0, (i % 3) == 0);
        wait_idle();
        rd(4'd2);

        // reset with a read in flight
        rd(4'd5);
        do_reset(2);
        wait_idle();

        // reset part way through a sweep
        step('0, '0, '0, 1'b0, '0, 1'b1);
        repeat (9) idle();
        do_reset(2);
        wait_idle();
        rd(4'd0); rd(4'd9); rd(4'd15);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            logic [NB-1:0] w;
            logic [AW-1:0] wa, ra;
            w  = ($urandom_range(2, 0) == 0) ? '0 : NB'($urandom_range(15, 0));
            wa = AW'($urandom_range(DEPTH - 1, 0));
            ra = ($urandom_range(3, 0) == 0) ? wa : AW'($urandom_range(DEPTH - 1, 0));
            step(w, wa, DW'($urandom), 1'($urandom_range(1, 0)), ra, $urandom_range(59, 0) == 0);
        end

        repeat (6) idle();
        chk("drain_0", DW'(exp_q[0].size()), '0);
        chk("drain_1", DW'(exp_q[1].size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
